// File: rtl/soc_rst_seq_pkg.sv
// Shared types and constants for the reset/clock-enable sequencer.
package soc_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_DELAY,
    ST_RELEASE,
    ST_STOP,
    ST_DONE
  } seq_state_e;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h1;
  localparam logic [3:0] ADDR_RESTART = 4'h2;
  localparam logic [3:0] ADDR_DELAY0  = 4'h4;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_LOCK_ERR = 2;
  localparam int STAT_IDX_LSB  = 4;
  localparam int STAT_LOCK_LSB = 8;

endpackage

// File: rtl/rst_seq_lock_sync.sv
// Multi-flop synchroniser for the asynchronous FLL lock inputs.
module rst_seq_lock_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/soc_rst_seq_ctrl.sv
// Reset/clock-enable sequencer: releases NB_DOMAINS domains in index order.
// state     | meaning
// IDLE      | first cycle out of reset
// WAIT_LOCK | waiting for lock of domain r_idx (or timeout)
// DELAY     | domain clock enabled, counting down to reset release
// RELEASE   | domain reset released, advance to next domain
// STOP      | restart accepted, gating clocks of domains >= r_idx
// DONE      | all domains running
module soc_rst_seq_ctrl
  import soc_rst_seq_pkg::*;
#(
  parameter int NB_DOMAINS    = 3,
  parameter int CNT_WIDTH     = 8,
  parameter int DEFAULT_DELAY = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_req_i,
  input  logic                  cfg_wrn_i,
  input  logic [3:0]            cfg_add_i,
  input  logic [31:0]           cfg_data_i,
  output logic                  cfg_ack_o,
  output logic [31:0]           cfg_r_data_o,
  input  logic [NB_DOMAINS-1:0] lock_i,
  output logic [NB_DOMAINS-1:0] clk_en_o,
  output logic [NB_DOMAINS-1:0] rstn_o,
  output logic                  seq_busy_o,
  output logic                  seq_done_o
);

  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(LOCK_TIMEOUT - 1);

  seq_state_e            r_state, w_state_nxt;
  logic [3:0]            r_idx;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_lock_err;
  logic [NB_DOMAINS-1:0] r_clk_en, r_rstn, r_lock_req;
  logic [CNT_WIDTH-1:0]  r_delay [NB_DOMAINS];
  logic                  r_ack;
  logic [31:0]           r_rdata;

  logic [NB_DOMAINS-1:0] w_lock_sync, w_cur_mask, w_k_mask, w_idx_ge_mask;
  logic                  w_cur_req, w_cur_lock;
  logic [CNT_WIDTH-1:0]  w_cur_delay;
  logic                  w_exit_wait, w_set_err, w_release, w_next_dom;
  logic                  w_wr, w_rd, w_restart, w_busy, w_done;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  rst_seq_lock_sync #(.WIDTH(NB_DOMAINS), .STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_async (lock_i),
    .o_sync  (w_lock_sync)
  );

  always_comb begin
    w_cur_mask    = '0;
    w_k_mask      = '0;
    w_idx_ge_mask = '0;
    w_cur_req     = 1'b0;
    w_cur_lock    = 1'b0;
    w_cur_delay   = '0;
    for (int i = 0; i < NB_DOMAINS; i++) begin
      if (r_idx == 4'(i)) begin
        w_cur_mask[i] = 1'b1;
        w_cur_req     = r_lock_req[i];
        w_cur_lock    = w_lock_sync[i];
        w_cur_delay   = r_delay[i];
      end
      w_k_mask[i]      = (4'(i) >= cfg_data_i[3:0]);
      w_idx_ge_mask[i] = (4'(i) >= r_idx);
    end
  end

  assign w_wr      = cfg_req_i & ~r_ack & ~cfg_wrn_i;
  assign w_rd      = cfg_req_i & ~r_ack & cfg_wrn_i;
  assign w_restart = w_wr && (cfg_add_i == ADDR_RESTART) && (r_state == ST_DONE)
                     && (cfg_data_i[3:0] < 4'(NB_DOMAINS));
  assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_done    = (r_state == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_exit_wait = 1'b0;
    w_set_err   = 1'b0;
    w_release   = 1'b0;
    w_next_dom  = 1'b0;
    unique case (r_state)
      ST_IDLE:      w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!w_cur_req || w_cur_lock || r_tmo == '0) begin
          w_exit_wait = 1'b1;
          w_set_err   = w_cur_req && !w_cur_lock;
          w_state_nxt = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (r_cnt == '0) begin
          w_release   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (r_idx == 4'(NB_DOMAINS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_next_dom  = 1'b1;
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_STOP:      w_state_nxt = ST_WAIT_LOCK;
      ST_DONE:      if (w_restart) w_state_nxt = ST_STOP;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tmo      <= TMO_LOAD;
      r_lock_err <= 1'b0;
      r_clk_en   <= '0;
      r_rstn     <= '0;
    end else begin
      // Timeout reloads whenever we are outside WAIT_LOCK.
      r_tmo <= (r_state == ST_WAIT_LOCK) ? r_tmo - TMO_W'(1) : TMO_LOAD;
      if (w_exit_wait) begin
        r_cnt    <= w_cur_delay;
        r_clk_en <= r_clk_en | w_cur_mask;
      end else if (r_state == ST_DELAY && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
      if (w_set_err)  r_lock_err <= 1'b1;
      if (w_release)  r_rstn <= r_rstn | w_cur_mask;
      if (w_next_dom) r_idx <= r_idx + 4'd1;
      if (w_restart) begin
        r_idx  <= cfg_data_i[3:0];
        r_rstn <= r_rstn & ~w_k_mask;
      end
      if (r_state == ST_STOP) r_clk_en <= r_clk_en & ~w_idx_ge_mask;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (cfg_add_i)
      ADDR_CTRL:   w_rdata[NB_DOMAINS-1:0] = r_lock_req;
      ADDR_STATUS: begin
        w_rdata[STAT_BUSY]                        = w_busy;
        w_rdata[STAT_DONE]                        = w_done;
        w_rdata[STAT_LOCK_ERR]                    = r_lock_err;
        w_rdata[STAT_IDX_LSB +: 4]                = r_idx;
        w_rdata[STAT_LOCK_LSB +: NB_DOMAINS]      = w_lock_sync;
      end
      default: ;
    endcase
    for (int i = 0; i < NB_DOMAINS; i++) begin
      if (cfg_add_i == ADDR_DELAY0 + 4'(i)) w_rdata = 32'(r_delay[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_lock_req <= '1;
      for (int i = 0; i < NB_DOMAINS; i++) r_delay[i] <= CNT_WIDTH'(DEFAULT_DELAY);
    end else begin
      r_ack   <= cfg_req_i & ~r_ack;
      r_rdata <= w_rd ? w_rdata : '0;
      if (w_wr && cfg_add_i == ADDR_CTRL) r_lock_req <= cfg_data_i[NB_DOMAINS-1:0];
      for (int i = 0; i < NB_DOMAINS; i++) begin
        if (w_wr && cfg_add_i == ADDR_DELAY0 + 4'(i)) r_delay[i] <= cfg_data_i[CNT_WIDTH-1:0];
      end
    end
  end

  assign w_unused     = ^cfg_data_i;
  assign cfg_ack_o    = r_ack;
  assign cfg_r_data_o = r_rdata;
  assign clk_en_o     = r_clk_en;
  assign rstn_o       = r_rstn;
  assign seq_busy_o   = w_busy;
  assign seq_done_o   = w_done;

endmodule

// File: tb/tb_soc_rst_seq_ctrl.sv
// Directed bench for soc_rst_seq_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_soc_rst_seq_ctrl;

  localparam int NB = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_req_i, cfg_wrn_i;
  logic [3:0]    cfg_add_i;
  logic [31:0]   cfg_data_i;
  logic          cfg_ack_o;
  logic [31:0]   cfg_r_data_o;
  logic [NB-1:0] lock_i, clk_en_o, rstn_o;
  logic          seq_busy_o, seq_done_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  soc_rst_seq_ctrl #(
    .NB_DOMAINS(NB), .CNT_WIDTH(8), .DEFAULT_DELAY(16), .LOCK_TIMEOUT(1024), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_wrn_i(cfg_wrn_i), .cfg_add_i(cfg_add_i), .cfg_data_i(cfg_data_i),
    .cfg_ack_o(cfg_ack_o), .cfg_r_data_o(cfg_r_data_o),
    .lock_i(lock_i), .clk_en_o(clk_en_o), .rstn_o(rstn_o),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (cfg_ack_o !== 1'b1 && n < 8);
    check("cfg_ack", cfg_ack_o, 1);
  endtask

  // Returns on the negedge of the ack cycle with req already dropped.
  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_req_i = 1'b1; cfg_wrn_i = 1'b0; cfg_add_i = a; cfg_data_i = d;
    wait_ack();
    cfg_req_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_req_i = 1'b1; cfg_wrn_i = 1'b1; cfg_add_i = a;
    wait_ack();
    d = cfg_r_data_o;
    cfg_req_i = 1'b0;
  endtask

  task automatic measure_gap(input int d, input int exp_gap, input logic [NB-1:0] exp_en,
                             input logic [NB-1:0] exp_rstn, input int budget, output time t_en);
    int cyc = 0;
    int gap = 0;
    while (clk_en_o[d] !== 1'b1 && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    t_en = $time;
    check($sformatf("clk_en_rise[%0d]", d), clk_en_o[d], 1);
    check($sformatf("en_vec_at_rise[%0d]", d), clk_en_o, exp_en);
    check($sformatf("rstn_vec_at_rise[%0d]", d), rstn_o, exp_rstn);
    while (rstn_o[d] !== 1'b1 && gap < 300) begin
      @(negedge clk_i);
      gap++;
    end
    check($sformatf("en_to_rstn_gap[%0d]", d), gap, exp_gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    time t0, t_en;
    int cyc;

    rst_i = 1'b1; cfg_req_i = 1'b0; cfg_wrn_i = 1'b0; cfg_add_i = '0; cfg_data_i = '0; lock_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_clk_en", clk_en_o, 0);
    check("rst_rstn", rstn_o, 0);
    check("rst_busy", seq_busy_o, 0);
    check("rst_done", seq_done_o, 0);
    check("rst_ack", cfg_ack_o, 0);
    check("rst_rdata", cfg_r_data_o, 0);

    // Reset release: IDLE for one cycle, then WAIT_LOCK(0).
    rst_i = 1'b0;
    check("idle_busy", seq_busy_o, 0);
    @(negedge clk_i);
    check("wait_lock0_busy", seq_busy_o, 1);

    // LOCK_REQ=0: all domains released in order with DELAY=16.
    cfg_write(4'h0, 32'h0);
    measure_gap(0, 17, 3'b001, 3'b000, 50, t_en);
    measure_gap(1, 17, 3'b011, 3'b001, 50, t_en);
    measure_gap(2, 17, 3'b111, 3'b011, 50, t_en);
    repeat (2) @(negedge clk_i);
    check("seq1_done", seq_done_o, 1);
    check("seq1_busy", seq_busy_o, 0);
    check("seq1_rstn", rstn_o, 3'b111);
    cfg_read(4'h1, rd);
    check("seq1_status", rd, 32'h22);
    cfg_read(4'h3, rd);
    check("unmapped_read", rd, 32'h0);

    // Restart from domain 1.
    cfg_write(4'h2, 32'h1);
    check("rs1_rstn_ack", rstn_o, 3'b001);
    check("rs1_en_ack", clk_en_o, 3'b111);
    check("rs1_done_drop", seq_done_o, 0);
    @(negedge clk_i);
    check("rs1_en_next", clk_en_o, 3'b001);
    measure_gap(1, 17, 3'b011, 3'b001, 50, t_en);
    measure_gap(2, 17, 3'b111, 3'b011, 50, t_en);
    repeat (2) @(negedge clk_i);
    check("rs1_done", seq_done_o, 1);

    // LOCK_REQ all ones, domain 1 lock held low then raised.
    cfg_write(4'h0, 32'h7);
    lock_i = 3'b001;
    cfg_write(4'h2, 32'h1);
    repeat (50) @(negedge clk_i);
    check("lock_hold_en", clk_en_o, 3'b001);
    check("lock_hold_busy", seq_busy_o, 1);
    lock_i[1] = 1'b1;
    cyc = 0;
    while (clk_en_o[1] !== 1'b1 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    check("lock_to_clk_en", cyc, 3);
    measure_gap(1, 17, 3'b011, 3'b001, 5, t_en);

    // Domain 2 never locks: forced progress after 1024 cycles in WAIT_LOCK.
    t0 = $time;
    @(negedge clk_i);
    cfg_read(4'h1, rd);
    check("wait2_status", rd, 32'h321);
    measure_gap(2, 17, 3'b111, 3'b011, 1100, t_en);
    check("timeout_cycles", 32'((t_en - t0) / 10), 1025);
    repeat (2) @(negedge clk_i);
    check("tmo_done", seq_done_o, 1);
    cfg_read(4'h1, rd);
    check("tmo_status", rd, 32'h326);

    // DELAY[0]=0; restart while busy is acked and ignored.
    cfg_write(4'h0, 32'h0);
    cfg_write(4'h4, 32'h0);
    cfg_write(4'h2, 32'h1);
    check("rs_busy_rstn_ack", rstn_o, 3'b001);
    @(negedge clk_i);
    check("rs_busy_en_next", clk_en_o, 3'b001);
    cfg_write(4'h2, 32'h0);
    check("ignored_rs_rstn", rstn_o, 3'b001);
    check("ignored_rs_busy", seq_busy_o, 1);
    measure_gap(1, 17, 3'b011, 3'b001, 10, t_en);
    measure_gap(2, 17, 3'b111, 3'b011, 50, t_en);
    repeat (2) @(negedge clk_i);
    check("ignored_rs_done", seq_done_o, 1);

    // Out-of-range start domain is ignored.
    cfg_write(4'h2, 32'h3);
    check("rs3_rstn", rstn_o, 3'b111);
    @(negedge clk_i);
    check("rs3_en", clk_en_o, 3'b111);
    check("rs3_done", seq_done_o, 1);

    // Restart from 0 with DELAY[0]=0: one-cycle gap.
    cfg_write(4'h2, 32'h0);
    check("rs0_rstn_ack", rstn_o, 3'b000);
    @(negedge clk_i);
    check("rs0_en_next", clk_en_o, 3'b000);
    measure_gap(0, 1, 3'b001, 3'b000, 10, t_en);
    cyc = 0;
    while (clk_en_o[1] !== 1'b1 && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    check("rs0_en1_rise", clk_en_o, 3'b011);

    // Async reset in the middle of DELAY(1).
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_en", clk_en_o, 0);
    check("async_rst_rstn", rstn_o, 0);
    check("async_rst_busy", seq_busy_o, 0);
    check("async_rst_done", seq_done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cfg_read(4'h4, rd);
    check("delay0_after_rst", rd, 32'h10);
    cfg_read(4'h6, rd);
    check("delay2_after_rst", rd, 32'h10);
    cfg_read(4'h0, rd);
    check("ctrl_after_rst", rd, 32'h7);
    cfg_write(4'h5, 32'hFFFF_FFAB);
    cfg_read(4'h5, rd);
    check("delay1_rw", rd, 32'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
